// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the seq_mult_n multiplier.
//   mult_state_e : controller states (idle, operand load, shift-add, done)
//   mult_sign_t  : captured signedness and operand sign flags
//   cnt_width()  : iteration counter width for a given operand width
package mult_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StCalc,
      StDone
   } mult_state_e;

   typedef struct packed {
      logic is_signed;
      logic sign_a;
      logic sign_b;
   } mult_sign_t;

   // Must be able to hold the value DW.
   function automatic int unsigned cnt_width(input int unsigned dw);
      return $clog2(dw) + 1;
   endfunction

endpackage

// File: rtl/mult_negate.sv
// mult_negate: combinational two's-complement negate with enable.
//   en_i  : 1 = output the negation of val_i, 0 = pass val_i through
//   val_i : W-bit input value
//   val_o : W-bit result
module mult_negate #(
   parameter int unsigned W = 8
) (
   input  logic         en_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] val_o
);

   always_comb begin
      val_o = val_i;
      if (en_i) begin
         val_o = ~val_i + W'(1);
      end
   end

endmodule

// File: rtl/seq_mult_n.sv
// seq_mult_n: sequential shift-add multiplier, signed or unsigned per request.
// Operands are reduced to magnitudes, multiplied with one shift-add step per
// cycle, and the result is negated when the operand signs differ.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : request, sampled only when idle
//   i_signed       : 1 = two's-complement operands, 0 = unsigned
//   i_multiplicand : operand A (DW bits)
//   i_multiplier   : operand B (DW bits)
//   o_busy         : high in every state except idle
//   o_ready        : one-cycle pulse, o_product valid
//   o_product      : 2*DW-bit result, held until the next o_ready
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave the shift-add loop as soon
// as the remaining multiplier bits are all zero.
module seq_mult_n
   import mult_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_signed,
   input  logic [DW-1:0]   i_multiplicand,
   input  logic [DW-1:0]   i_multiplier,
   output logic            o_busy,
   output logic            o_ready,
   output logic [2*DW-1:0] o_product
);

   localparam int unsigned CW = cnt_width(DW);

   mult_state_e     state_q, state_d;
   mult_sign_t      sign_q, sign_d;
   logic [2*DW-1:0] mcand_q, mcand_d;
   logic [DW-1:0]   mplier_q, mplier_d;
   logic [2*DW-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*DW-1:0] product_q, product_d;

   logic            neg_a_en, neg_b_en;
   logic [DW-1:0]   mag_a, mag_b;
   logic [2*DW-1:0] acc_sum, prod_signed;
   logic [DW-1:0]   mplier_shift;
   logic            last_iter;

   assign neg_a_en     = sign_q.is_signed & mcand_q[DW-1];
   assign neg_b_en     = sign_q.is_signed & mplier_q[DW-1];
   assign acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mplier_shift = mplier_q >> 1;

   // Magnitude of -2^(DW-1) is 2^(DW-1): still fits as DW-bit unsigned.
   mult_negate #(.W(DW)) u_mag_a (
      .en_i  (neg_a_en),
      .val_i (mcand_q[DW-1:0]),
      .val_o (mag_a)
   );

   mult_negate #(.W(DW)) u_mag_b (
      .en_i  (neg_b_en),
      .val_i (mplier_q),
      .val_o (mag_b)
   );

   // Applied to the final accumulator value so the product register is
   // already correct when DONE is entered.
   mult_negate #(.W(2*DW)) u_prod (
      .en_i  (sign_q.sign_a ^ sign_q.sign_b),
      .val_i (acc_sum),
      .val_o (prod_signed)
   );

   always_comb begin
      last_iter = (cnt_q == CW'(DW - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
      last_iter = last_iter | (mplier_shift == '0);
`endif
   end

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               mcand_d          = {{DW{1'b0}}, i_multiplicand};
               mplier_d         = i_multiplier;
               sign_d.is_signed = i_signed;
               sign_d.sign_a    = 1'b0;
               sign_d.sign_b    = 1'b0;
               state_d          = StLoad;
            end
         end
         StLoad: begin
            mcand_d       = {{DW{1'b0}}, mag_a};
            mplier_d      = mag_b;
            sign_d.sign_a = neg_a_en;
            sign_d.sign_b = neg_b_en;
            acc_d         = '0;
            cnt_d         = '0;
            state_d       = StCalc;
         end
         StCalc: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shift;
            cnt_d    = cnt_q + CW'(1);
            if (last_iter) begin
               product_d = prod_signed;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         sign_q    <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign o_busy    = (state_q != StIdle);
   assign o_ready   = (state_q == StDone);
   assign o_product = product_q;

endmodule

// File: tb/tb_seq_mult_n.sv
// tb_seq_mult_n: scoreboard bench for seq_mult_n (DW = 8). Expected products
// and ready cycles are queued when a request is issued and compared when
// o_ready pulses. Honours SEQ_MULT_EARLY_TERM_EN for expected latency.
module tb_seq_mult_n;

   localparam int unsigned DW = 8;

   typedef struct {
      logic [2*DW-1:0] prod;
      int              cyc;
      string           tag;
   } exp_t;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b1;
   logic            i_start = 1'b0;
   logic            i_signed = 1'b0;
   logic [DW-1:0]   i_multiplicand = '0;
   logic [DW-1:0]   i_multiplier = '0;
   logic            o_busy;
   logic            o_ready;
   logic [2*DW-1:0] o_product;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   seq_mult_n #(.DW(DW)) u_dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_signed       (i_signed),
      .i_multiplicand (i_multiplicand),
      .i_multiplier   (i_multiplier),
      .o_busy         (o_busy),
      .o_ready        (o_ready),
      .o_product      (o_product)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint unsigned got,
                        input longint unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*DW-1:0] model(input bit s, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      longint p;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'(a) * longint'(b);
      return p[2*DW-1:0];
   endfunction

   function automatic int lat(input bit s, input logic [DW-1:0] b);
      logic [DW-1:0] m;
      int h;
      m = (s && b[DW-1]) ? -b : b;
      h = 0;
      for (int i = 0; i < DW; i++) if (m[i]) h = i + 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
      return (h + 2 < 3) ? 3 : h + 2;
`else
      return (h >= 0) ? DW + 2 : 0;
`endif
   endfunction

   // Issue a request at the first idle negedge; returns its cycle-0 index.
   task automatic start_req(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input string tag, output int k);
      int   guard;
      exp_t e;
      guard = 0;
      while (o_busy && guard < 50) begin
         @(negedge i_clk);
         guard++;
      end
      check({tag, "_idle"}, o_busy, 0);
      k              = cyc;
      i_start        = 1'b1;
      i_signed       = s;
      i_multiplicand = a;
      i_multiplier   = b;
      e.prod = model(s, a, b);
      e.cyc  = k + lat(s, b);
      e.tag  = tag;
      sb_q.push_back(e);
      @(negedge i_clk);
      // Scramble inputs: only the captured copies may matter.
      i_start        = 1'b0;
      i_signed       = 1'($urandom);
      i_multiplicand = DW'($urandom);
      i_multiplier   = DW'($urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         @(negedge i_clk);
         guard++;
      end
      check("drain", sb_q.size(), 0);
   endtask

   always @(negedge i_clk) begin
      if (o_ready) begin
         if (sb_q.size() == 0) begin
            check("spurious_ready", o_ready, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, "_prod"}, o_product, mon_e.prod);
            check({mon_e.tag, "_cycle"}, cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      int   k;
      int   l;
      exp_t dummy;
      bit   s;
      logic [DW-1:0] a, b;

      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_ready, 0);
      check("rst_product", o_product, 0);

      // Unsigned max x max with per-cycle busy profile.
      start_req(0, 8'hFF, 8'hFF, "u_ff_ff", k);
      l = lat(0, 8'hFF);
      for (int n = 1; n <= l + 1; n++) begin
         check($sformatf("u_ff_ff_busy_c%0d", n), o_busy, (n <= l) ? 1 : 0);
         @(negedge i_clk);
      end

      start_req(1, 8'h80, 8'h80, "s_80_80", k);
      start_req(1, 8'hFD, 8'h05, "s_fd_05", k);
      start_req(0, 8'hFD, 8'h05, "u_fd_05", k);
      start_req(1, 8'h00, 8'h80, "s_00_80", k);
      drain();

      // Extra start pulses while busy (incl. DONE cycle) must be ignored.
      start_req(0, 8'd7, 8'd9, "ign_7_9", k);
      l = lat(0, 8'd9);
      for (int n = 1; n <= l; n++) begin
         if (n == 4 || n == l) begin
            i_start        = 1'b1;
            i_multiplicand = 8'd3;
            i_multiplier   = 8'd3;
         end else begin
            i_start = 1'b0;
         end
         @(negedge i_clk);
      end
      i_start = 1'b0;
      start_req(0, 8'd3, 8'd3, "after_ign", k);
      check("after_ign_k", k - (cyc - 1), 0);
      drain();

      // Reset in cycle 5 aborts the request.
      start_req(1, 8'h23, 8'h11, "rst_abort", k);
      repeat (4) @(negedge i_clk);
      i_rst = 1'b1;
      dummy = sb_q.pop_back();
      @(negedge i_clk);
      i_rst = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_ready", o_ready, 0);
      check("abort_product", o_product, 0);
      repeat (15) @(negedge i_clk);

      // Multiplier-dependent latency (early-termination build).
      start_req(1, 8'h05, 8'h00, "et_05_00", k);
      start_req(1, 8'h05, 8'h04, "et_05_04", k);
      start_req(1, 8'h7F, 8'h01, "et_7f_01", k);
      drain();

      for (int i = 0; i < 12; i++) begin
         s = 1'($urandom);
         a = DW'($urandom);
         b = DW'($urandom);
         start_req(s, a, b, $sformatf("rand%0d", i), k);
      end
      drain();
      repeat (3) @(negedge i_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
